// File: rtl/lfsr_share_ctrl.sv
//------------------------------------------------------------------------------
// lfsr_share_ctrl
//
// Round-robin scheduler owning one 13-bit Fibonacci LFSR
// (tap = r[0]^r[2]^r[3]^r[12], shift left, tap into bit 0) shared between
// NREQ requesters. A granted requester receives a burst of req_len bits, one
// per RUN cycle. The controller counts the ones delivered and pulses done at
// the end of the burst. The LFSR only advances while bits are delivered, so
// the sequence is continuous across bursts and requesters.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   LEN_W  width of a burst-length field
//   SEED   reset seed, also substituted for an all-zero seed_val
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   req         in   [NREQ]        per-requester burst request (level)
//   req_len     in   [NREQ*LEN_W]  burst lengths, requester i at [i*LEN_W +: LEN_W]
//   seed_load   in   load seed_val into the LFSR (honoured in IDLE only)
//   seed_val    in   [13]          seed value
//   gnt         out  [NREQ]        registered one-hot grant
//   bit_out     out  current random bit, lfsr[12]
//   bit_valid   out  bit_out is a delivered bit (RUN)
//   done        out  one-cycle end-of-burst pulse
//   ones_cnt    out  [LEN_W]       ones delivered so far in the current burst
//   busy        out  controller not in IDLE
//   lfsr_state  out  [13]          current LFSR register
//------------------------------------------------------------------------------
module lfsr_share_ctrl #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LEN_W = 8,
   parameter logic [12:0] SEED  = 13'h100D
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*LEN_W-1:0]   req_len,
   input  logic                    seed_load,
   input  logic [12:0]             seed_val,
   output logic [NREQ-1:0]         gnt,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic                    done,
   output logic [LEN_W-1:0]        ones_cnt,
   output logic                    busy,
   output logic [12:0]             lfsr_state
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [NREQ-1:0]      gnt_q,   gnt_d;
   logic [IDX_W-1:0]     idx_q,   idx_d;
   logic [IDX_W-1:0]     rr_q,    rr_d;
   logic [LEN_W-1:0]     rem_q,   rem_d;
   logic [LEN_W-1:0]     ones_q,  ones_d;
   logic [12:0]          lfsr_q,  lfsr_d;

   // Unpacked view of the per-requester length fields.
   logic [LEN_W-1:0]     len_a [NREQ];

   // Arbitration result.
   logic                 arb_hit;
   logic [IDX_W-1:0]     arb_idx;
   logic [LEN_W-1:0]     arb_len;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
      assign len_a[gi] = req_len[gi*LEN_W +: LEN_W];
   end

   function automatic logic [12:0] lfsr_next(input logic [12:0] r);
      logic tap;
      tap = r[0] ^ r[2] ^ r[3] ^ r[12];
      return {r[11:0], tap};
   endfunction

   //---------------------------------------------------------------------------
   // Round-robin search: first set request at or above rr_q, wrapping.
   //---------------------------------------------------------------------------
   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      arb_hit  = 1'b0;
      arb_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = 32'(rr_q) + off;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IDX_W'(cand);
         if (!arb_hit && req[cand_idx]) begin
            arb_hit = 1'b1;
            arb_idx = cand_idx;
         end
      end
   end

   assign arb_len = len_a[arb_idx];

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
         rem_q   <= '0;
         ones_q  <= '0;
         lfsr_q  <= SEED;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         rem_q   <= rem_d;
         ones_q  <= ones_d;
         lfsr_q  <= lfsr_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and datapath
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      rem_d   = rem_q;
      ones_d  = ones_q;
      lfsr_d  = lfsr_q;

      unique case (state_q)
         S_IDLE: begin
            // A seed load and a grant may share an edge; the burst then
            // starts from the freshly loaded seed.
            if (seed_load) begin
               lfsr_d = (seed_val == '0) ? SEED : seed_val;
            end
            if (arb_hit) begin
               gnt_d   = NREQ'(1) << arb_idx;
               idx_d   = arb_idx;
               rem_d   = arb_len;
               ones_d  = '0;
               state_d = (arb_len != '0) ? S_RUN : S_DONE;
            end
         end

         S_RUN: begin
            lfsr_d = lfsr_next(lfsr_q);
            rem_d  = rem_q - LEN_W'(1);
            ones_d = ones_q + LEN_W'(lfsr_q[12]);
            if (rem_q == LEN_W'(1)) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            gnt_d   = '0;
            rr_d    = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   always_comb begin
      gnt        = gnt_q;
      bit_out    = lfsr_q[12];
      bit_valid  = (state_q == S_RUN);
      done       = (state_q == S_DONE);
      ones_cnt   = ones_q;
      busy       = (state_q != S_IDLE);
      lfsr_state = lfsr_q;
   end

endmodule
